// File: rtl/xor_unit_arbiter_pkg.sv
// xor_arb_pkg: shared types, default sizes and the round-robin search helper
// used by the XOR unit arbiter.
package xor_arb_pkg;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} xarb_state_t;

   localparam int NREQ_DEF = 4;
   localparam int DW_DEF   = 8;

   function automatic int rr_next(input logic [31:0] valid, input int last, input int n = NREQ_DEF);
      int idx;
      rr_next = 0;
      // Walk from farthest to nearest so the nearest valid slot after last wins.
      for (int k = n; k >= 1; k--) begin
         idx = (last + k) % n;
         if (valid[idx]) rr_next = idx;
      end
   endfunction

endpackage

// File: rtl/xor_unit_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant search starting after last_i.
module rr_arbiter
   import xor_arb_pkg::*;
#(
   parameter int  NREQ = NREQ_DEF,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  last_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   assign any_o = |req_i;
   assign idx_o = IDW'(rr_next(32'(req_i), int'(last_i), NREQ));
   assign gnt_o = any_o ? (NREQ'(1) << idx_o) : '0;

endmodule

// File: rtl/xor_unit_arbiter.sv
// xor_unit_arbiter: one registered XOR unit shared round-robin by NREQ requesters.
// Defining XOR_UNIT_ARBITER_PARITY_EN adds the rsp_parity output.
module xor_unit_arbiter
   import xor_arb_pkg::*;
#(
   parameter int  NREQ = NREQ_DEF,
   parameter int  DW   = DW_DEF,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*DW-1:0] req_a,
   input  logic [NREQ*DW-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [IDW-1:0]   rsp_id,
   output logic [DW-1:0]    rsp_data,
   output logic             busy
`ifdef XOR_UNIT_ARBITER_PARITY_EN
   ,
   output logic             rsp_parity
`endif
);

   xarb_state_t     state_q;
   logic [IDW-1:0]  last_q, id_q, rsp_id_q, gnt_idx;
   logic [NREQ-1:0] gnt_oh;
   logic            any_valid, rsp_valid_q;
   logic [DW-1:0]   a_q, b_q, a_d, b_d, rsp_data_q;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req_i (req_valid),
      .last_i(last_q),
      .gnt_o (gnt_oh),
      .idx_o (gnt_idx),
      .any_o (any_valid)
   );

   assign a_d       = req_a[int'(gnt_idx)*DW +: DW];
   assign b_d       = req_b[int'(gnt_idx)*DW +: DW];
   assign req_ready = (state_q == IDLE) ? gnt_oh : '0;
   assign busy      = (state_q != IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

`ifdef XOR_UNIT_ARBITER_PARITY_EN
   logic rsp_parity_q;
   assign rsp_parity = rsp_parity_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         last_q      <= IDW'(NREQ - 1);
         id_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
`ifdef XOR_UNIT_ARBITER_PARITY_EN
         rsp_parity_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: if (any_valid) begin
               a_q     <= a_d;
               b_q     <= b_d;
               id_q    <= gnt_idx;
               state_q <= EXEC;
            end
            EXEC: begin
               rsp_data_q  <= a_q ^ b_q;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
`ifdef XOR_UNIT_ARBITER_PARITY_EN
               rsp_parity_q <= ^(a_q ^ b_q);
`endif
               state_q     <= RESP;
            end
            RESP: if (rsp_ready) begin
               // Pointer moves only once the result has been taken.
               rsp_valid_q <= 1'b0;
               last_q      <= id_q;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// tb_xor_unit_arbiter: directed scoreboard bench for xor_unit_arbiter (NREQ=4, DW=8).
module tb_xor_unit_arbiter;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] d;
      logic       p;
   } exp_t;

   logic        clk, rst, rsp_valid, rsp_ready, busy;
   logic [3:0]  req_valid, req_ready;
   logic [31:0] req_a, req_b;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_data;
`ifdef XOR_UNIT_ARBITER_PARITY_EN
   logic        rsp_parity;
`endif

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   xor_unit_arbiter #(.NREQ(4), .DW(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data),
      .busy(busy)
`ifdef XOR_UNIT_ARBITER_PARITY_EN
      , .rsp_parity(rsp_parity)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int id, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      e.id = 2'(id);
      e.d  = a ^ b;
      e.p  = ^(a ^ b);
      exp_q.push_back(e);
   endtask

   // Drive one request at a negedge, see it granted, leave it at the EXEC negedge.
   task automatic issue(input string tag, input int id, input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      req_a[id*8 +: 8] = a;
      req_b[id*8 +: 8] = b;
      req_valid[id]    = 1'b1;
      push(id, a, b);
      #1;
      while (!req_ready[id] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_grant"}, 32'(req_ready), 32'(4'b1 << id));
      @(negedge clk);
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_rsp(input string tag);
      exp_t e;
      int n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1));
      chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(e.id));
         chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(e.d));
`ifdef XOR_UNIT_ARBITER_PARITY_EN
         chk({tag, "_rsp_parity"}, 32'(rsp_parity), 32'(e.p));
`endif
      end
      if (rsp_ready) @(negedge clk);
   endtask

   logic [7:0] tt_a [4] = '{8'h00, 8'h00, 8'hFF, 8'hFF};
   logic [7:0] tt_b [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
   int         rr_order [5] = '{0, 1, 2, 3, 0};

   initial begin
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);

      // Basic operation with explicit cycle-by-cycle checks.
      req_a[7:0] = 8'hA5; req_b[7:0] = 8'h0F; req_valid = 4'b0001;
      push(0, 8'hA5, 8'h0F);
      #1;
      chk("basic_grant", 32'(req_ready), 32'h1);
      chk("basic_idle_busy", 32'(busy), 0);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("basic_exec_busy", 32'(busy), 1);
      chk("basic_exec_rsp_valid", 32'(rsp_valid), 0);
      chk("basic_exec_req_ready", 32'(req_ready), 0);
      @(negedge clk);
      chk("basic_resp_busy", 32'(busy), 1);
      chk("basic_resp_valid_now", 32'(rsp_valid), 1);
      wait_rsp("basic");
      chk("basic_done_busy", 32'(busy), 0);
      chk("basic_done_rsp_valid", 32'(rsp_valid), 0);

      // Truth-table sweep on requester 1.
      for (int i = 0; i < 4; i++) begin
         issue($sformatf("tt%0d", i), 1, tt_a[i], tt_b[i]);
         wait_rsp($sformatf("tt%0d", i));
      end

      // Backpressure on requester 3 while the others request.
      rsp_ready = 1'b0;
      issue("bp", 3, 8'h3C, 8'h55);
      req_valid = 4'b0111;
      wait_rsp("bp");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp_hold_valid%0d", i), 32'(rsp_valid), 1);
         chk($sformatf("bp_hold_data%0d", i), 32'(rsp_data), 32'h69);
         chk($sformatf("bp_hold_id%0d", i), 32'(rsp_id), 3);
         chk($sformatf("bp_hold_ready%0d", i), 32'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      req_valid = '0;
      @(negedge clk);
      chk("bp_release_valid", 32'(rsp_valid), 0);
      chk("bp_release_busy", 32'(busy), 0);

      // Round-robin with all four requesters held valid.
      for (int i = 0; i < 4; i++) begin
         req_a[i*8 +: 8] = 8'(i * 16 + 1);
         req_b[i*8 +: 8] = 8'h5A;
      end
      foreach (rr_order[k]) push(rr_order[k], 8'(rr_order[k] * 16 + 1), 8'h5A);
      req_valid = 4'b1111;
      #1;
      for (int k = 0; k < 5; k++) begin
         int n = 0;
         while (req_ready == 4'b0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
         end
         chk($sformatf("rr%0d_grant", k), 32'(req_ready), 32'(4'b1 << rr_order[k]));
         @(negedge clk);
         wait_rsp($sformatf("rr%0d", k));
         #1;
      end
      req_valid = '0;
      @(negedge clk);

      // Reset while the unit is in EXEC; the captured operation is dropped.
      issue("mid", 1, 8'h12, 8'h34);
      void'(exp_q.pop_back());
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
      chk("mid_rst_rsp_data", 32'(rsp_data), 0);
      chk("mid_rst_rsp_id", 32'(rsp_id), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("mid_no_rsp%0d", i), 32'(rsp_valid), 0);
      end
      issue("post_rst", 2, 8'hF0, 8'h3C);
      wait_rsp("post_rst");

`ifdef XOR_UNIT_ARBITER_PARITY_EN
      issue("par_odd", 0, 8'h07, 8'h00);
      wait_rsp("par_odd");
      issue("par_even", 1, 8'h03, 8'h00);
      wait_rsp("par_even");
`endif

      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
